// File: rtl/weight_sequencer.sv
// Streams one layer of signed weights from a registered weight ROM to a MAC datapath using a valid/ready handshake.
// Optional build macro WSEQ_BIAS_EN appends one bias word, read from the next ROM address, to every neuron.
module weight_sequencer #(
    parameter int N = 8,
    parameter int Q = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          base_addr,
    input  logic [7:0]          num_inputs,
    input  logic [7:0]          num_neurons,
    output logic [7:0]          rom_addr,
    input  logic signed [N-1:0] rom_data,
    output logic signed [N-1:0] w_data,
    output logic                w_valid,
    input  logic                w_ready,
    output logic                w_last_neuron,
    output logic                w_last_layer,
    output logic [7:0]          neuron_idx,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PRIME  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

`ifdef WSEQ_BIAS_EN
    localparam logic [8:0] BIAS_WORDS = 9'd1;
`else
    localparam logic [8:0] BIAS_WORDS = 9'd0;
`endif

    // Q only documents the fixed-point format of the data passing through.
    if (Q >= N) begin : g_q_range
        $error("weight_sequencer: Q must be smaller than N");
    end

    logic [1:0]          state_q, state_d;
    logic [7:0]          rom_addr_q, rom_addr_d;
    logic signed [N-1:0] w_data_q, w_data_d;
    logic                w_valid_q, w_valid_d;
    logic                last_neuron_q, last_neuron_d;
    logic                last_layer_q, last_layer_d;
    logic [7:0]          neuron_idx_q, neuron_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [8:0]          wpn_q, wpn_d;
    logic [8:0]          in_idx_q, in_idx_d;
    logic [15:0]         rem_q, rem_d;

    logic                fire_s;
    logic [8:0]          wpn_s;
    logic [15:0]         total_s;
    logic [8:0]          nxt_in_idx_s;

    assign fire_s       = w_valid_q & w_ready;
    assign wpn_s        = {1'b0, num_inputs} + BIAS_WORDS;
    assign total_s      = {7'd0, wpn_s} * {8'd0, num_neurons};
    assign nxt_in_idx_s = last_neuron_q ? 9'd0 : (in_idx_q + 9'd1);

    // Next-state logic; rem_q counts words still to come after the one on w_data.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        w_data_d      = w_data_q;
        w_valid_d     = w_valid_q;
        last_neuron_d = last_neuron_q;
        last_layer_d  = last_layer_q;
        neuron_idx_d  = neuron_idx_q;
        wpn_d         = wpn_q;
        in_idx_d      = in_idx_q;
        rem_d         = rem_q;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((num_inputs != 8'd0) && (num_neurons != 8'd0)) begin
                        rom_addr_d = base_addr;
                        wpn_d      = wpn_s;
                        rem_d      = total_s - 16'd1;
                        state_d    = PRIME;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME: begin
                w_data_d      = rom_data;
                w_valid_d     = 1'b1;
                rom_addr_d    = rom_addr_q + 8'd1;
                in_idx_d      = 9'd0;
                neuron_idx_d  = 8'd0;
                last_neuron_d = (wpn_q == 9'd1);
                last_layer_d  = (rem_q == 16'd0);
                state_d       = STREAM;
            end
            STREAM: begin
                if (fire_s) begin
                    if (last_layer_q) begin
                        w_valid_d     = 1'b0;
                        last_neuron_d = 1'b0;
                        last_layer_d  = 1'b0;
                        done_d        = 1'b1;
                        state_d       = DRAIN;
                    end else begin
                        w_data_d      = rom_data;
                        rom_addr_d    = rom_addr_q + 8'd1;
                        in_idx_d      = nxt_in_idx_s;
                        neuron_idx_d  = neuron_idx_q + {7'd0, last_neuron_q};
                        last_neuron_d = (nxt_in_idx_s == (wpn_q - 9'd1));
                        rem_d         = rem_q - 16'd1;
                        last_layer_d  = (rem_q == 16'd1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rom_addr_q    <= 8'd0;
            w_data_q      <= '0;
            w_valid_q     <= 1'b0;
            last_neuron_q <= 1'b0;
            last_layer_q  <= 1'b0;
            neuron_idx_q  <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wpn_q         <= 9'd0;
            in_idx_q      <= 9'd0;
            rem_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            w_data_q      <= w_data_d;
            w_valid_q     <= w_valid_d;
            last_neuron_q <= last_neuron_d;
            last_layer_q  <= last_layer_d;
            neuron_idx_q  <= neuron_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wpn_q         <= wpn_d;
            in_idx_q      <= in_idx_d;
            rem_q         <= rem_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign w_data        = w_data_q;
    assign w_valid       = w_valid_q;
    assign w_last_neuron = last_neuron_q;
    assign w_last_layer  = last_layer_q;
    assign neuron_idx    = neuron_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_weight_sequencer.sv
// Directed bench for weight_sequencer against a ROM model holding ROM[i] = i, registered on the falling edge.
module tb_weight_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        base_addr;
    logic [7:0]        num_inputs;
    logic [7:0]        num_neurons;
    logic [7:0]        rom_addr;
    logic signed [7:0] rom_data;
    logic signed [7:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              w_last_neuron;
    logic              w_last_layer;
    logic [7:0]        neuron_idx;
    logic              busy;
    logic              done;

    int compared = 0;
    int mismatched = 0;

    weight_sequencer #(.N(8), .Q(7)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_inputs(num_inputs), .num_neurons(num_neurons), .rom_addr(rom_addr),
        .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last_neuron(w_last_neuron), .w_last_layer(w_last_layer),
        .neuron_idx(neuron_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) rom_data <= rom_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".rom_addr"}, {8'd0, rom_addr}, 16'h0000);
        chk({tag, ".w_data"}, {8'd0, w_data}, 16'h0000);
        chk({tag, ".w_valid"}, {15'd0, w_valid}, 16'h0000);
        chk({tag, ".last_n"}, {15'd0, w_last_neuron}, 16'h0000);
        chk({tag, ".last_l"}, {15'd0, w_last_layer}, 16'h0000);
        chk({tag, ".nidx"}, {8'd0, neuron_idx}, 16'h0000);
        chk({tag, ".busy"}, {15'd0, busy}, 16'h0000);
        chk({tag, ".done"}, {15'd0, done}, 16'h0000);
    endtask

    // One presented word: value, flags and neuron index.
    task automatic chk_word(input string tag, input logic [7:0] d, input logic ln,
                            input logic ll, input logic [7:0] ni);
        chk({tag, ".valid"}, {15'd0, w_valid}, 16'h0001);
        chk({tag, ".data"}, {8'd0, w_data}, {8'd0, d});
        chk({tag, ".last_n"}, {15'd0, w_last_neuron}, {15'd0, ln});
        chk({tag, ".last_l"}, {15'd0, w_last_layer}, {15'd0, ll});
        chk({tag, ".nidx"}, {8'd0, neuron_idx}, {8'd0, ni});
    endtask

    task automatic kick(input logic [7:0] b, input logic [7:0] ni, input logic [7:0] nn);
        start = 1'b1; base_addr = b; num_inputs = ni; num_neurons = nn;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 8'd0; num_inputs = 8'd0;
        num_neurons = 8'd0; w_ready = 1'b1;
        #1;
        chk_idle_zero("reset");
        step(); step();
        rst = 1'b0;
        step();

        // Basic 3x2 layer at full throughput, plus start during DRAIN ignored.
        kick(8'h10, 8'd3, 8'd2);
        chk("t1.busy_prime", {15'd0, busy}, 16'h0001);
        chk("t1.addr_prime", {8'd0, rom_addr}, 16'h0010);
        chk("t1.valid_prime", {15'd0, w_valid}, 16'h0000);
        step();
        for (int k = 0; k < 6; k++) begin
            chk_word($sformatf("t1.w%0d", k), 8'h10 + 8'(k), (k == 2) || (k == 5),
                     (k == 5), 8'(k / 3));
            step();
        end
        chk("t1.done", {15'd0, done}, 16'h0001);
        chk("t1.valid_off", {15'd0, w_valid}, 16'h0000);
        start = 1'b1; base_addr = 8'h55; num_inputs = 8'd1; num_neurons = 8'd1;
        step();
        start = 1'b0;
        chk("t1.done_end", {15'd0, done}, 16'h0000);
        chk("t1.drain_start_ign", {15'd0, busy}, 16'h0000);
        step();
        chk("t1.still_idle", {15'd0, busy}, 16'h0000);

        // Backpressure on 0x11 for three cycles with a stray start.
        kick(8'h10, 8'd3, 8'd2);
        step();
        chk_word("t2.w0", 8'h10, 1'b0, 1'b0, 8'd0);
        step();
        w_ready = 1'b0; start = 1'b1; base_addr = 8'h80;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t2.hold_data%0d", k), {8'd0, w_data}, 16'h0011);
            chk($sformatf("t2.hold_addr%0d", k), {8'd0, rom_addr}, 16'h0012);
            chk($sformatf("t2.hold_valid%0d", k), {15'd0, w_valid}, 16'h0001);
        end
        start = 1'b0; w_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            chk_word($sformatf("t2.w%0d", k), 8'h10 + 8'(k), (k == 2) || (k == 5),
                     (k == 5), 8'(k / 3));
            step();
        end
        chk("t2.done", {15'd0, done}, 16'h0001);
        step(); step();

        // Address wrap through 0xFF.
        kick(8'hFE, 8'd4, 8'd1);
        chk("t3.addr0", {8'd0, rom_addr}, 16'h00FE);
        step();
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("t3.w%0d", k), 8'hFE + 8'(k), (k == 3), (k == 3), 8'd0);
            chk($sformatf("t3.addr%0d", k + 1), {8'd0, rom_addr}, {8'd0, 8'hFF + 8'(k)});
            step();
        end
        chk("t3.done", {15'd0, done}, 16'h0001);
        step(); step();

        // Empty layer.
        kick(8'h30, 8'd5, 8'd0);
        chk("t4.done", {15'd0, done}, 16'h0001);
        chk("t4.busy", {15'd0, busy}, 16'h0000);
        chk("t4.valid", {15'd0, w_valid}, 16'h0000);
        step();
        chk("t4.done_off", {15'd0, done}, 16'h0000);
        chk("t4.valid_off", {15'd0, w_valid}, 16'h0000);

        // Reset after the second fire, then a fresh layer.
        kick(8'h20, 8'd3, 8'd2);
        step();
        step();
        step();
        chk("t5.pre_rst", {8'd0, w_data}, 16'h0022);
        rst = 1'b1;
        #1;
        chk_idle_zero("t5.async");
        step();
        chk("t5.no_done", {15'd0, done}, 16'h0000);
        rst = 1'b0;
        step();
        chk("t5.no_done2", {15'd0, done}, 16'h0000);
        kick(8'h40, 8'd2, 8'd1);
        step();
        chk_word("t5.w0", 8'h40, 1'b0, 1'b0, 8'd0);
        step();
        chk_word("t5.w1", 8'h41, 1'b1, 1'b1, 8'd0);
        step();
        chk("t5.done", {15'd0, done}, 16'h0001);
        step(); step();

`ifdef WSEQ_BIAS_EN
        // Bias word appended to each neuron.
        kick(8'h00, 8'd2, 8'd2);
        step();
        for (int k = 0; k < 6; k++) begin
            chk_word($sformatf("t6.w%0d", k), 8'(k), (k == 2) || (k == 5), (k == 5), 8'(k / 3));
            step();
        end
        chk("t6.done", {15'd0, done}, 16'h0001);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
